// File: rtl/ddr_cache_pkg.sv
// ddr_cache_pkg: shared widths, FSM state encoding and a word-select helper for the DDR-side
// data cache (ddr_cache_ctrl and cache_line_store).
package ddr_cache_pkg;

  localparam int unsigned HALF_W         = 128;
  localparam int unsigned LINE_W         = 2 * HALF_W;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned WORDS_PER_LINE = LINE_W / WORD_W;
  localparam int unsigned WORD_OFF_W     = $clog2(WORDS_PER_LINE);
  localparam int unsigned STATE_W        = 3;

  typedef enum logic [STATE_W-1:0] {
    StIdle = 3'd0,
    StWb0  = 3'd1,
    StWb1  = 3'd2,
    StRf0  = 3'd3,
    StRf1  = 3'd4,
    StFill = 3'd5
  } state_e;

  // Word w of a line lives in bits [32w+31:32w].
  function automatic logic [WORD_W-1:0] get_word(input logic [LINE_W-1:0]     line,
                                                 input logic [WORD_OFF_W-1:0] w);
    return line[{w, 5'b00000} +: WORD_W];
  endfunction

endpackage

// File: rtl/ddr_cache_ctrl_if.sv
// ddr_cache_ctrl_if: CPU-side and DDR-controller-side signals of the cache.
//   slave  : the cache view (takes CPU requests and controller status, drives replies and ram_*).
//   master : the environment view (CPU plus DDR controller).
interface ddr_cache_ctrl_if #(
  parameter int unsigned ADDR_W = 30
);
  import ddr_cache_pkg::*;

  logic              cpu_en;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_addr;
  logic [WORD_W-1:0] cpu_wdata;
  logic [3:0]        cpu_byte_en;
  logic [WORD_W-1:0] cpu_rdata;
  logic              cpu_rdy;
  logic              ram_en;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_addr;
  logic [LINE_W-1:0] data_to_ram;
  logic              ram_rdy;
  logic [LINE_W-1:0] block_out;

  modport slave (
    input  cpu_en, cpu_write, cpu_addr, cpu_wdata, cpu_byte_en, ram_rdy, block_out,
    output cpu_rdata, cpu_rdy, ram_en, ram_write, ram_addr, data_to_ram
  );

  modport master (
    output cpu_en, cpu_write, cpu_addr, cpu_wdata, cpu_byte_en, ram_rdy, block_out,
    input  cpu_rdata, cpu_rdy, ram_en, ram_write, ram_addr, data_to_ram
  );

endinterface

// File: rtl/cache_line_store.sv
// cache_line_store: valid/dirty/tag/data arrays of a direct-mapped cache.
//   i_clk, i_rst      : clock, synchronous active-low clear of valid/dirty only.
//   i_rd_idx, o_rd_*  : combinational read of one line with its tag and status bits.
//   i_wr_*            : byte-enabled store of one word; marks the line dirty.
//   i_fill_*          : full-line fill; marks the line valid and clean.
module cache_line_store
  import ddr_cache_pkg::*;
#(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned TAG_W = 21
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [IDX_W-1:0]      i_rd_idx,
  output logic                  o_rd_valid,
  output logic                  o_rd_dirty,
  output logic [TAG_W-1:0]      o_rd_tag,
  output logic [LINE_W-1:0]     o_rd_line,
  input  logic                  i_wr_en,
  input  logic [IDX_W-1:0]      i_wr_idx,
  input  logic [WORD_OFF_W-1:0] i_wr_word,
  input  logic [WORD_W-1:0]     i_wr_data,
  input  logic [3:0]            i_wr_be,
  input  logic                  i_fill_en,
  input  logic [IDX_W-1:0]      i_fill_idx,
  input  logic [TAG_W-1:0]      i_fill_tag,
  input  logic [LINE_W-1:0]     i_fill_line
);
  localparam int unsigned NLines = 2 ** IDX_W;

  logic [NLines-1:0] r_valid;
  logic [NLines-1:0] r_dirty;
  logic [TAG_W-1:0]  r_tag  [NLines];
  logic [LINE_W-1:0] r_data [NLines];

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_dirty = r_dirty[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_line  = r_data[i_rd_idx];

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_en) begin
      r_valid[i_fill_idx] <= 1'b1;
      r_dirty[i_fill_idx] <= 1'b0;
    end else if (i_wr_en) begin
      r_dirty[i_wr_idx] <= 1'b1;
    end
  end

  // Arrays have no reset; writes are held off while reset is asserted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      if (i_fill_en) begin
        r_data[i_fill_idx] <= i_fill_line;
        r_tag[i_fill_idx]  <= i_fill_tag;
      end else if (i_wr_en) begin
        for (int b = 0; b < 4; b++) begin
          if (i_wr_be[b]) begin
            r_data[i_wr_idx][{i_wr_word, b[1:0], 3'b000} +: 8] <= i_wr_data[{b[1:0], 3'b000} +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/ddr_cache_ctrl.sv
// ddr_cache_ctrl: direct-mapped, write-back, write-allocate cache in front of a DDR controller.
//   i_clk : ui_clk from the controller (the controller samples ram_* on the falling edge).
//   i_rst : synchronous active-low reset.
//   bus   : CPU word port (cpu_*) and 128-bit half-line port to the controller (ram_*).
// A miss writes back the dirty victim in two halves (WB0/WB1), reads the new line in two
// halves (RF0/RF1), fills it, and then lets the held CPU request hit in IDLE.
module ddr_cache_ctrl
  import ddr_cache_pkg::*;
#(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned ADDR_W = 30
) (
  input logic              i_clk,
  input logic              i_rst,
  ddr_cache_ctrl_if.slave  bus
);
  localparam int unsigned TAG_W = ADDR_W - WORD_OFF_W - IDX_W;

  state_e              r_state, w_state_nxt;
  logic                r_held, w_held_nxt;
  logic [IDX_W-1:0]    r_idx;
  logic [TAG_W-1:0]    r_req_tag;
  logic [TAG_W-1:0]    r_victim_tag;
  logic [LINE_W-1:0]   r_victim_line;

  logic [IDX_W-1:0]      w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic [WORD_OFF_W-1:0] w_word;
  logic                  w_valid, w_dirty, w_hit, w_advance;
  logic [TAG_W-1:0]      w_stored_tag;
  logic [LINE_W-1:0]     w_line;
  logic                  w_latch, w_wr_en, w_fill_en;

  assign w_word = bus.cpu_addr[WORD_OFF_W-1:0];
  assign w_idx  = bus.cpu_addr[IDX_W+WORD_OFF_W-1:WORD_OFF_W];
  assign w_tag  = bus.cpu_addr[ADDR_W-1:ADDR_W-TAG_W];
  assign w_hit  = w_valid && (w_stored_tag == w_tag);
  // The first cycle of each ram op ignores ram_rdy: the controller has not reacted yet.
  assign w_advance = r_held && bus.ram_rdy;

  assign bus.data_to_ram = r_victim_line;

  cache_line_store #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_store (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rd_idx    (w_idx),
    .o_rd_valid  (w_valid),
    .o_rd_dirty  (w_dirty),
    .o_rd_tag    (w_stored_tag),
    .o_rd_line   (w_line),
    .i_wr_en     (w_wr_en),
    .i_wr_idx    (w_idx),
    .i_wr_word   (w_word),
    .i_wr_data   (bus.cpu_wdata),
    .i_wr_be     (bus.cpu_byte_en),
    .i_fill_en   (w_fill_en),
    .i_fill_idx  (r_idx),
    .i_fill_tag  (r_req_tag),
    .i_fill_line (bus.block_out)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_held_nxt    = 1'b1;
    w_latch       = 1'b0;
    w_wr_en       = 1'b0;
    w_fill_en     = 1'b0;
    bus.ram_en    = 1'b0;
    bus.ram_write = 1'b0;
    bus.ram_addr  = '0;
    bus.cpu_rdy   = !bus.cpu_en;
    bus.cpu_rdata = '0;
    unique case (r_state)
      StIdle: begin
        w_held_nxt = 1'b0;
        if (bus.cpu_en && i_rst) begin
          if (w_hit) begin
            bus.cpu_rdy = 1'b1;
            if (bus.cpu_write) begin
              w_wr_en = 1'b1;
            end else begin
              bus.cpu_rdata = get_word(w_line, w_word);
            end
          end else begin
            w_latch     = 1'b1;
            w_state_nxt = (w_valid && w_dirty) ? StWb0 : StRf0;
          end
        end
      end
      StWb0, StWb1: begin
        bus.ram_en    = 1'b1;
        bus.ram_write = 1'b1;
        bus.ram_addr  = {r_victim_tag, r_idx, (r_state == StWb1), 2'b00};
        if (w_advance) begin
          w_state_nxt = (r_state == StWb0) ? StWb1 : StRf0;
          w_held_nxt  = 1'b0;
        end
      end
      StRf0, StRf1: begin
        bus.ram_en   = 1'b1;
        bus.ram_addr = {r_req_tag, r_idx, (r_state == StRf1), 2'b00};
        if (w_advance) begin
          w_state_nxt = (r_state == StRf0) ? StRf1 : StFill;
          w_held_nxt  = 1'b0;
        end
      end
      StFill: begin
        w_fill_en   = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= StIdle;
      r_held        <= 1'b0;
      r_idx         <= '0;
      r_req_tag     <= '0;
      r_victim_tag  <= '0;
      r_victim_line <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_held  <= w_held_nxt;
      if (w_latch) begin
        r_idx         <= w_idx;
        r_req_tag     <= w_tag;
        r_victim_tag  <= w_stored_tag;
        r_victim_line <= w_line;
      end
    end
  end

endmodule
